// File: rtl/huffman_encoder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | huffman_encoder_if                                                       |
// | Symbol handshake and serial output bundle for huffman_encoder.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface huffman_encoder_if #(
  parameter int SYM_W = 5
);
  logic [SYM_W-1:0] symbol_i;
  logic             valid_i;
  logic             ready_o;
  logic             serial_o;
  logic             sout_valid_o;
  logic             busy_o;
  logic             err_o;

  modport master (
    output symbol_i, valid_i,
    input  ready_o, serial_o, sout_valid_o, busy_o, err_o
  );

  modport slave (
    input  symbol_i, valid_i,
    output ready_o, serial_o, sout_valid_o, busy_o, err_o
  );
endinterface
`default_nettype wire

// File: rtl/huffman_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | huffman_encoder                                                          |
// | Serial MSB-first transmitter for the 18-symbol Huffman code with a fixed |
// | idle gap after each codeword. Optional macro: HUFF_ENC_ERR_EN (err_o).   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module huffman_encoder #(
  parameter int SYM_W      = 5,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  huffman_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam logic [2:0] c_GAP_M1 = 3'(GAP_CYCLES - 1);

  state_t     r_state,  w_state_nxt;
  logic [7:0] r_shreg,  w_shreg_nxt;
  logic [2:0] r_bitcnt, w_bitcnt_nxt;
  logic [2:0] r_gapcnt, w_gapcnt_nxt;
  logic       r_serial, w_serial_nxt;
  logic       r_sval,   w_sval_nxt;

  logic [7:0] w_code;
  logic [3:0] w_len;
  logic       w_legal;
  logic       w_ready;
  logic       w_accept;

  // Codebook ROM: code left-aligned in 8 bits, len of 0 marks an illegal symbol.
  always_comb begin
    w_code = 8'h00;
    w_len  = 4'd0;
    case (bus.symbol_i)
      5'd1:    begin w_code = 8'b0000_0000; w_len = 4'd2; end
      5'd2:    begin w_code = 8'b0100_0000; w_len = 4'd2; end
      5'd3:    begin w_code = 8'b1000_0000; w_len = 4'd2; end
      5'd4:    begin w_code = 8'b1100_0000; w_len = 4'd3; end
      5'd5:    begin w_code = 8'b1110_0000; w_len = 4'd6; end
      5'd6:    begin w_code = 8'b1110_0100; w_len = 4'd6; end
      5'd7:    begin w_code = 8'b1110_1000; w_len = 4'd6; end
      5'd8:    begin w_code = 8'b1110_1100; w_len = 4'd7; end
      5'd9:    begin w_code = 8'b1110_1110; w_len = 4'd7; end
      5'd10:   begin w_code = 8'b1111_0000; w_len = 4'd7; end
      5'd11:   begin w_code = 8'b1111_0010; w_len = 4'd7; end
      5'd12:   begin w_code = 8'b1111_0100; w_len = 4'd7; end
      5'd13:   begin w_code = 8'b1111_0110; w_len = 4'd7; end
      5'd14:   begin w_code = 8'b1111_1000; w_len = 4'd7; end
      5'd15:   begin w_code = 8'b1111_1010; w_len = 4'd7; end
      5'd16:   begin w_code = 8'b1111_1100; w_len = 4'd7; end
      5'd17:   begin w_code = 8'b1111_1110; w_len = 4'd8; end
      5'd18:   begin w_code = 8'b1111_1111; w_len = 4'd8; end
      default: begin w_code = 8'h00;        w_len = 4'd0; end
    endcase
  end

  assign w_legal  = (w_len != 4'd0);
  assign w_ready  = (r_state == S_IDLE) || ((r_state == S_GAP) && (r_gapcnt == 3'd0));
  assign w_accept = bus.valid_i && w_ready;

  always_comb begin
    w_state_nxt  = r_state;
    w_shreg_nxt  = r_shreg;
    w_bitcnt_nxt = r_bitcnt;
    w_gapcnt_nxt = r_gapcnt;
    w_serial_nxt = 1'b0;
    w_sval_nxt   = 1'b0;
    case (r_state)
      S_IDLE: ;
      S_SHIFT: begin
        if (r_bitcnt != 3'd0) begin
          w_serial_nxt = r_shreg[7];
          w_sval_nxt   = 1'b1;
          w_shreg_nxt  = {r_shreg[6:0], 1'b0};
          w_bitcnt_nxt = r_bitcnt - 3'd1;
        end else begin
          w_state_nxt  = S_GAP;
          w_gapcnt_nxt = c_GAP_M1;
        end
      end
      S_GAP: begin
        if (r_gapcnt != 3'd0) w_gapcnt_nxt = r_gapcnt - 3'd1;
        else                  w_state_nxt  = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // The first bit leaves on the accepting edge, so bitcnt holds the bits still to send.
    if (w_accept && w_legal) begin
      w_state_nxt  = S_SHIFT;
      w_serial_nxt = w_code[7];
      w_sval_nxt   = 1'b1;
      w_shreg_nxt  = {w_code[6:0], 1'b0};
      w_bitcnt_nxt = w_len[2:0] - 3'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state  <= S_IDLE;
      r_shreg  <= 8'h00;
      r_bitcnt <= 3'd0;
      r_gapcnt <= 3'd0;
      r_serial <= 1'b0;
      r_sval   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shreg  <= w_shreg_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_gapcnt <= w_gapcnt_nxt;
      r_serial <= w_serial_nxt;
      r_sval   <= w_sval_nxt;
    end
  end

`ifdef HUFF_ENC_ERR_EN
  logic        r_err;
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_err     <= 1'b0;
      r_err_cnt <= 16'd0;
    end else begin
      r_err <= w_accept && !w_legal;
      if (w_accept && !w_legal && (r_err_cnt != 16'hFFFF))
        r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign bus.err_o = r_err;
`else
  assign bus.err_o = 1'b0;
`endif

  assign bus.ready_o      = w_ready;
  assign bus.serial_o     = r_serial;
  assign bus.sout_valid_o = r_sval;
  assign bus.busy_o       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_huffman_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_huffman_encoder                                                       |
// | Directed bench with a per-cycle expected-output queue for the encoder.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_huffman_encoder;

  localparam int GAP = 1;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;
  bit   mon_en;
  logic exp_err;
  time  acc_t;
  time  prev_t;
  string cb[32];

  // Entry per output cycle: {sout_valid, serial, ready}
  logic [2:0] q[$];

  huffman_encoder_if #(.SYM_W(5)) bus ();

  huffman_encoder #(
    .SYM_W      (5),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic [2:0] e;
    logic       busy_exp;
    if (mon_en) begin
      if (q.size() > 0) begin
        e        = q.pop_front();
        busy_exp = 1'b1;
      end else begin
        e        = 3'b001;
        busy_exp = 1'b0;
      end
      checks++;
      assert (bus.sout_valid_o === e[2]) else begin
        errors++; $error("FAIL sout_valid t=%0t observed=%b expected=%b", $time, bus.sout_valid_o, e[2]);
      end
      checks++;
      assert (bus.serial_o === e[1]) else begin
        errors++; $error("FAIL serial t=%0t observed=%b expected=%b", $time, bus.serial_o, e[1]);
      end
      checks++;
      assert (bus.ready_o === e[0]) else begin
        errors++; $error("FAIL ready t=%0t observed=%b expected=%b", $time, bus.ready_o, e[0]);
      end
      checks++;
      assert (bus.busy_o === busy_exp) else begin
        errors++; $error("FAIL busy t=%0t observed=%b expected=%b", $time, bus.busy_o, busy_exp);
      end
      checks++;
      assert (bus.err_o === exp_err) else begin
        errors++; $error("FAIL err t=%0t observed=%b expected=%b", $time, bus.err_o, exp_err);
      end
      exp_err = 1'b0;
    end
  end

  // Leaves valid_i high; the caller drops it with idle() when the burst ends.
  task automatic send(input logic [4:0] s);
    int n;
    n = 0;
    bus.symbol_i = s;
    bus.valid_i  = 1'b1;
    while (bus.ready_o !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    assert (n < 50) else begin
      errors++; $error("FAIL ready_timeout sym=%0d observed_wait=%0d expected_wait=<50", s, n);
    end
    @(posedge clk);
    acc_t = $time;
    for (int i = 0; i < cb[s].len(); i++)
      q.push_back({1'b1, (cb[s].getc(i) == 8'h31), 1'b0});
    if (cb[s].len() > 0) begin
      for (int g = 0; g < GAP; g++)
        q.push_back({1'b0, 1'b0, (g == GAP - 1)});
    end else begin
`ifdef HUFF_ENC_ERR_EN
      exp_err = 1'b1;
`endif
    end
    #1;
  endtask

  task automatic idle();
    bus.valid_i  = 1'b0;
    bus.symbol_i = 5'($urandom_range(0, 31));
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_spacing(input string tag, input time dt, input time want);
    checks++;
    assert (dt === want) else begin
      errors++; $error("FAIL %s observed=%0t expected=%0t", tag, dt, want);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    assert (bus.serial_o === 1'b0) else begin
      errors++; $error("FAIL %s_serial observed=%b expected=0", tag, bus.serial_o);
    end
    checks++;
    assert (bus.sout_valid_o === 1'b0) else begin
      errors++; $error("FAIL %s_sval observed=%b expected=0", tag, bus.sout_valid_o);
    end
    checks++;
    assert (bus.busy_o === 1'b0) else begin
      errors++; $error("FAIL %s_busy observed=%b expected=0", tag, bus.busy_o);
    end
    checks++;
    assert (bus.err_o === 1'b0) else begin
      errors++; $error("FAIL %s_err observed=%b expected=0", tag, bus.err_o);
    end
    checks++;
    assert (bus.ready_o === 1'b1) else begin
      errors++; $error("FAIL %s_ready observed=%b expected=1", tag, bus.ready_o);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cb[1]  = "00";       cb[2]  = "01";       cb[3]  = "10";
    cb[4]  = "110";      cb[5]  = "111000";   cb[6]  = "111001";
    cb[7]  = "111010";   cb[8]  = "1110110";  cb[9]  = "1110111";
    cb[10] = "1111000";  cb[11] = "1111001";  cb[12] = "1111010";
    cb[13] = "1111011";  cb[14] = "1111100";  cb[15] = "1111101";
    cb[16] = "1111110";  cb[17] = "11111110"; cb[18] = "11111111";

    checks       = 0;
    errors       = 0;
    mon_en       = 1'b0;
    exp_err      = 1'b0;
    rstn         = 1'b0;
    bus.valid_i  = 1'b0;
    bus.symbol_i = 5'd0;

    // Reset state
    #12;
    check_reset_outputs("reset_state");
    @(negedge clk); #1;
    rstn   = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Idle after release
    wait_cycles(5);

    // Single symbol 4
    send(5'd4);
    idle();
    wait_cycles(6);

    // 17 then 18 with valid held
    send(5'd17);
    prev_t = acc_t;
    send(5'd18);
    check_spacing("b2b_17_18", acc_t - prev_t, 90);
    idle();
    wait_cycles(12);

    // Stream 1,2,3,9
    send(5'd1);
    prev_t = acc_t;
    send(5'd2);
    check_spacing("b2b_1_2", acc_t - prev_t, 30);
    prev_t = acc_t;
    send(5'd3);
    check_spacing("b2b_2_3", acc_t - prev_t, 30);
    prev_t = acc_t;
    send(5'd9);
    check_spacing("b2b_3_9", acc_t - prev_t, 30);
    idle();
    wait_cycles(10);

    // Illegal symbols consumed without output
    send(5'd0);
    prev_t = acc_t;
    send(5'd19);
    check_spacing("illegal_0_19", acc_t - prev_t, 10);
    idle();
    wait_cycles(4);

    // Reset mid-codeword
    send(5'd12);
    idle();
    repeat (3) @(negedge clk);
    #1;
    mon_en = 1'b0;
    rstn   = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    q.delete();
    exp_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rstn   = 1'b1;
    mon_en = 1'b1;
    wait_cycles(2);
    send(5'd3);
    idle();
    wait_cycles(5);

    checks++;
    assert (q.size() == 0) else begin
      errors++; $error("FAIL queue_drained observed=%0d expected=0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
